// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: one BLK-bit block resolved per stage, valid/ready on both sides.
// Optional signed-overflow output enabled by defining CSEL_OVF_DET_EN.
`timescale 1ns/1ps
module pipelined_csel_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
`ifdef CSEL_OVF_DET_EN
  output logic             ovf,
`endif
  output logic             Cout
);

  localparam int NBLK = WIDTH / BLK;

  logic [NBLK-1:0]  v_q;
  logic [NBLK-1:0]  cy_q;
  logic [WIDTH-1:0] opa_q [NBLK];
  logic [WIDTH-1:0] opb_q [NBLK];
  logic [WIDTH-1:0] sum_q [NBLK];

  logic [NBLK-1:0]  vin;
  logic [NBLK-1:0]  cin;
  logic [NBLK-1:0]  cy_d;
  logic [WIDTH-1:0] ain   [NBLK];
  logic [WIDTH-1:0] bin   [NBLK];
  logic [WIDTH-1:0] sin   [NBLK];
  logic [WIDTH-1:0] sum_d [NBLK];
  logic [BLK:0]     r0    [NBLK];
  logic [BLK:0]     r1    [NBLK];
  logic [BLK:0]     sel   [NBLK];

  logic stall;

  assign stall     = v_q[NBLK-1] && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = v_q[NBLK-1];
  assign Sum       = sum_q[NBLK-1];
  assign Cout      = cy_q[NBLK-1];

  // Operand B is inverted once at entry, so every later stage is a plain adder.
  always_comb begin
    vin[0] = in_valid;
    ain[0] = a;
    bin[0] = sub ? ~b : b;
    cin[0] = sub ? 1'b1 : Cin;
    sin[0] = '0;
    for (int k = 1; k < NBLK; k++) begin
      vin[k] = v_q[k-1];
      ain[k] = opa_q[k-1];
      bin[k] = opb_q[k-1];
      cin[k] = cy_q[k-1];
      sin[k] = sum_q[k-1];
    end
    for (int k = 0; k < NBLK; k++) begin
      r0[k]  = {1'b0, ain[k][k*BLK +: BLK]} + {1'b0, bin[k][k*BLK +: BLK]};
      r1[k]  = {1'b0, ain[k][k*BLK +: BLK]} + {1'b0, bin[k][k*BLK +: BLK]}
             + {{BLK{1'b0}}, 1'b1};
      sel[k] = cin[k] ? r1[k] : r0[k];
      sum_d[k] = sin[k];
      sum_d[k][k*BLK +: BLK] = sel[k][BLK-1:0];
      cy_d[k] = sel[k][BLK];
    end
  end

`ifdef CSEL_OVF_DET_EN
  logic ovf_q;
  logic ovf_d;
  // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
  assign ovf_d = sum_d[NBLK-1][WIDTH-1] ^ ain[NBLK-1][WIDTH-1]
               ^ bin[NBLK-1][WIDTH-1] ^ cy_d[NBLK-1];
  assign ovf   = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ovf_q <= 1'b0;
    else if (!stall && vin[NBLK-1])      ovf_q <= ovf_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      cy_q <= '0;
      for (int k = 0; k < NBLK; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        sum_q[k] <= '0;
      end
    end else if (!stall) begin
      v_q <= vin;
      for (int k = 0; k < NBLK; k++) begin
        opa_q[k] <= ain[k];
        opb_q[k] <= bin[k];
      end
      for (int k = 0; k < NBLK-1; k++) begin
        sum_q[k] <= sum_d[k];
        cy_q[k]  <= cy_d[k];
      end
      // Output register only changes when a real beat arrives.
      if (vin[NBLK-1]) begin
        sum_q[NBLK-1] <= sum_d[NBLK-1];
        cy_q[NBLK-1]  <= cy_d[NBLK-1];
      end
    end
  end

endmodule

// File: doc/pipelined_csel_adder.md
Name: pipelined_csel_adder

Overview:
- Parametrised, pipelined carry-select adder/subtractor; successor to the team's 4-bit combinational carry-select adder.
- Splits WIDTH-bit operands into NBLK = WIDTH/BLK blocks. Each block precomputes sums for carry-in 0 and 1, then selects using the registered carry of the previous block. One pipeline stage per block.
- Valid/ready handshake on both sides; full backpressure; throughput one operation per cycle.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of BLK.
- BLK, 4, carry-select block width; NBLK = WIDTH/BLK pipeline stages, NBLK >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- Cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: a+b+Cin; 1: a-b, computed as a+~b+1 with Cin ignored.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- Sum  output  WIDTH  result.
- Cout  output  1  carry-out of MSB; for sub=1, 1 means no borrow (a>=b unsigned).

Behaviour:
- Reset (async assert, release synchronous to clk): all stage valid bits=0, out_valid=0, Sum=0, Cout=0, all carry/partial registers=0. in_ready=1 once reset is released.
- Transfer rules: input handshake when in_valid&&in_ready at a rising edge; output handshake when out_valid&&out_ready.
- Stall: stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - During stall every pipeline register holds, including Sum, Cout and out_valid. Output stays stable until accepted.
- Advance: when !stall, every stage moves forward one position.
  - Stage 0 captures valid = in_valid.
  - Bubbles (valid=0) propagate; no bubble collapsing.
- Stage k, 0..NBLK-1, for a valid beat:
  - Computes s0/c0 = A_k+B_k+0 and s1/c1 = A_k+B_k+1 for bits [k*BLK +: BLK], where B = sub ? ~b : b.
  - Selects s/c using carry from stage k-1 register; stage 0 uses cin_eff = sub ? 1 : Cin.
  - Registers the selected partial sum bits, the carry, and the still-unprocessed upper operand bits. Upper operand bits are skewed along the pipeline with the beat.
- Latency: beat accepted at edge t gives out_valid=1 from just after edge t+NBLK-1, i.e. NBLK cycles (4 at defaults), with no stall.
- Output: Sum is the full WIDTH-bit result mod 2^WIDTH; Cout is the carry of the final block.
- Arithmetic: unsigned modular. Width of every block adder is BLK+1.
- Boundaries:
  - Back-to-back beats must not interfere.
  - A stall while the pipe is partially filled keeps all in-flight beats in order.
  - Simultaneous output accept and input accept in the same cycle is legal and lossless.
  - NBLK=1 degenerates to a single registered carry-select stage.
- Reset mid-operation drops all in-flight beats immediately; out_valid=0 asynchronously.
- Values of invalid stages are don't-care internally, but Sum/Cout update only when a valid beat reaches the output register.

Optional Feature:
- Macro CSEL_OVF_DET_EN.
- When defined: extra output port ovf (1 bit), pipelined with Sum and reset to 0. ovf = signed two's-complement overflow, i.e. carry into MSB XOR carry out of MSB of the final block, for both add and sub.
- When undefined: no ovf port and no associated logic.

Test Plan:
- Reset then single beat, WIDTH=16, BLK=4: a=16'hFFFF, b=16'h0001, Cin=0, sub=0 -> after 4 cycles out_valid=1, Sum=16'h0000, Cout=1; carry ripples through all blocks.
- Subtraction: a=16'h0005, b=16'h0007, sub=1 -> Sum=16'hFFFE, Cout=0. Then a=16'h0007, b=16'h0005 -> Sum=16'h0002, Cout=1.
- Streaming: 256 back-to-back beats with out_ready=1, random a/b/Cin/sub -> one result per cycle, in order, all matching the reference model; in_ready stays 1.
- Backpressure: pipe full, out_ready=0 for 5 cycles -> in_ready=0, Sum/Cout/out_valid frozen. Then release -> no beat lost or duplicated.
- Async reset asserted mid-stream with 3 beats in flight -> out_valid=0 immediately, Sum=0. After release the first new beat emerges alone with correct latency.
- With CSEL_OVF_DET_EN: a=16'h7FFF, b=16'h0001, sub=0 -> Sum=16'h8000, ovf=1, Cout=0. Also a=16'h8000, b=16'h0001, sub=1 -> Sum=16'h7FFF, ovf=1.
